// File: rtl/audio_pdm_sequencer_if.sv
// audio_pdm_sequencer_if: command, PDM mic, FIFO and amplifier signals of the audio sequencer.
// AUDIO_SEQ_LOOPBACK_EN adds the cmd_loop command line.
interface audio_pdm_sequencer_if;
    logic       cmd_rec;
    logic       cmd_play;
    logic       cmd_stop;
`ifdef AUDIO_SEQ_LOOPBACK_EN
    logic       cmd_loop;
`endif
    logic       mclk;
    logic       mic_data;
    logic       fifo_wr;
    logic       fifo_din;
    logic       fifo_full;
    logic       fifo_rd;
    logic       fifo_dout;
    logic       fifo_empty;
    logic       amp_pwm;
    logic       amp_sd;
    logic [1:0] state;
    logic       done;
    logic       overrun;
    modport master (
        input  cmd_rec, cmd_play, cmd_stop,
`ifdef AUDIO_SEQ_LOOPBACK_EN
        input  cmd_loop,
`endif
        input  mic_data, fifo_full, fifo_dout, fifo_empty,
        output mclk, fifo_wr, fifo_din, fifo_rd, amp_pwm, amp_sd, state, done, overrun
    );
    modport slave (
        output cmd_rec, cmd_play, cmd_stop,
`ifdef AUDIO_SEQ_LOOPBACK_EN
        output cmd_loop,
`endif
        output mic_data, fifo_full, fifo_dout, fifo_empty,
        input  mclk, fifo_wr, fifo_din, fifo_rd, amp_pwm, amp_sd, state, done, overrun
    );
endinterface

// File: rtl/audio_pdm_sequencer.sv
// audio_pdm_sequencer: PDM mic -> FIFO record and FIFO -> PWM playback sequencer.
// AUDIO_SEQ_LOOPBACK_EN adds a LOOP state routing the mic straight to the amplifier.
module audio_pdm_sequencer #(
    parameter int CLK_DIV  = 50,
    parameter int REC_BITS = 65536,
    parameter int CNT_W    = 17
) (
    input logic clk,
    input logic reset,
    audio_pdm_sequencer_if.master bus
);
    localparam int DIV_W = $clog2(CLK_DIV);
    typedef enum logic [1:0] {IDLE = 2'b00, REC = 2'b01, PLAY = 2'b10, LOOP = 2'b11} state_t;
    state_t st;
    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic mclk_i, rd_ld, loop_cmd, term, tick, restart;
`ifdef AUDIO_SEQ_LOOPBACK_EN
    assign loop_cmd = bus.cmd_loop;
`else
    assign loop_cmd = 1'b0;
`endif
    assign term    = div_cnt == DIV_W'(CLK_DIV - 1);
    assign tick    = term && !mclk_i;
    assign restart = st == IDLE && !bus.cmd_stop && (bus.cmd_rec || loop_cmd);
    assign bus.mclk  = mclk_i && (st == REC || st == LOOP);
    assign bus.state = st;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st          <= IDLE;
            div_cnt     <= '0;
            mclk_i      <= 1'b0;
            bit_cnt     <= '0;
            rd_ld       <= 1'b0;
            bus.fifo_wr <= 1'b0;
            bus.fifo_din <= 1'b0;
            bus.fifo_rd <= 1'b0;
            bus.amp_pwm <= 1'b0;
            bus.amp_sd  <= 1'b0;
            bus.done    <= 1'b0;
            bus.overrun <= 1'b0;
        end else begin
            bus.fifo_wr <= 1'b0;
            bus.fifo_rd <= 1'b0;
            bus.done    <= 1'b0;
            rd_ld       <= bus.fifo_rd;
            div_cnt     <= (restart || term) ? '0 : div_cnt + 1'b1;
            mclk_i      <= restart ? 1'b0 : (term ? !mclk_i : mclk_i);
            case (st)
                IDLE: if (!bus.cmd_stop) begin
                    if (bus.cmd_rec) begin
                        st          <= REC;
                        bit_cnt     <= '0;
                        bus.overrun <= 1'b0;
                    end else if (loop_cmd) begin
                        st         <= LOOP;
                        bus.amp_sd <= 1'b1;
                    end else if (bus.cmd_play) begin
                        if (bus.fifo_empty) bus.done <= 1'b1;
                        else begin
                            st         <= PLAY;
                            bus.amp_sd <= 1'b1;
                        end
                    end
                end
                // Stop and end-of-record win over a tick, so no write follows them.
                REC: if (bus.cmd_stop || bit_cnt == CNT_W'(REC_BITS)) begin
                    st       <= IDLE;
                    bus.done <= 1'b1;
                end else if (tick) begin
                    if (bus.fifo_full) begin
                        st          <= IDLE;
                        bus.done    <= 1'b1;
                        bus.overrun <= 1'b1;
                    end else begin
                        bus.fifo_wr  <= 1'b1;
                        bus.fifo_din <= bus.mic_data;
                        bit_cnt      <= bit_cnt + 1'b1;
                    end
                end
                PLAY: if (bus.cmd_stop || (tick && bus.fifo_empty)) begin
                    st          <= IDLE;
                    bus.done    <= 1'b1;
                    bus.amp_pwm <= 1'b0;
                    bus.amp_sd  <= 1'b0;
                end else begin
                    if (tick) bus.fifo_rd <= 1'b1;
                    if (rd_ld) bus.amp_pwm <= bus.fifo_dout;
                end
                default: if (bus.cmd_stop) begin
                    st          <= IDLE;
                    bus.done    <= 1'b1;
                    bus.amp_pwm <= 1'b0;
                    bus.amp_sd  <= 1'b0;
                end else if (tick) bus.amp_pwm <= bus.mic_data;
            endcase
        end
    end
endmodule

// File: tb/tb_audio_pdm_sequencer.sv
// tb_audio_pdm_sequencer: directed checks of record, overrun, playback, empty-play and stop
// handling with CLK_DIV=4, REC_BITS=16 against a small behavioural FIFO.
module tb_audio_pdm_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic full_force = 1'b0, pre_wr = 1'b0, pre_bit = 1'b0, flush = 1'b0;
    int n_cmp = 0, n_bad = 0;
    int cyc = 0, wp = 0, rp = 0, wcount = 0, rcount = 0, done_cnt = 0, bad_strobe = 0;
    logic mem [32];
    logic wr_bit [64];
    int wr_t [64];
    int rd_t [16];
    logic dout = 1'b0;
    audio_pdm_sequencer_if bus();
    audio_pdm_sequencer #(.CLK_DIV(4), .REC_BITS(16), .CNT_W(17)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    assign bus.fifo_full  = full_force;
    assign bus.fifo_empty = (wp == rp);
    assign bus.fifo_dout  = dout;
    assign bus.mic_data   = (wcount % 2 == 0);
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.done) done_cnt <= done_cnt + 1;
        if (bus.fifo_wr && (bus.fifo_full || bus.fifo_rd)) bad_strobe <= bad_strobe + 1;
        if (flush) rp <= wp;
        else if (bus.fifo_rd) begin
            dout <= mem[rp % 32];
            rp <= rp + 1;
            rd_t[rcount % 16] <= cyc;
            rcount <= rcount + 1;
        end
        if (bus.fifo_wr || pre_wr) begin
            mem[wp % 32] <= bus.fifo_wr ? bus.fifo_din : pre_bit;
            wp <= wp + 1;
        end
        if (bus.fifo_wr) begin
            wr_bit[wcount % 64] <= bus.fifo_din;
            wr_t[wcount % 64] <= cyc;
            wcount <= wcount + 1;
        end
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic issue(input logic r, input logic p, input logic s);
        bus.cmd_rec = r;
        bus.cmd_play = p;
        bus.cmd_stop = s;
        @(negedge clk);
        bus.cmd_rec = 1'b0;
        bus.cmd_play = 1'b0;
        bus.cmd_stop = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        int w0, r0, d0, last, cd, n, sd_bad;
        logic [3:0] pat;
        logic pwm_seen [4];
        bus.cmd_rec = 1'b0;
        bus.cmd_play = 1'b0;
        bus.cmd_stop = 1'b0;
`ifdef AUDIO_SEQ_LOOPBACK_EN
        bus.cmd_loop = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_outputs", {bus.mclk, bus.fifo_wr, bus.fifo_din, bus.fifo_rd, bus.amp_pwm, bus.amp_sd, bus.done, bus.overrun}, 0);
        reset = 1'b0;
        @(negedge clk);
        // 1: reset in the middle of a recording
        issue(1, 0, 0);
        chk("rec_entry", 32'(bus.state), 1);
        repeat (6) @(negedge clk);
        chk("rec_mclk_high", 32'(bus.mclk), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_state", 32'(bus.state), 0);
        chk("async_rst_outputs", {bus.mclk, bus.fifo_wr, bus.fifo_din, bus.fifo_rd, bus.amp_pwm, bus.amp_sd, bus.done, bus.overrun}, 0);
        @(negedge clk);
        reset = 1'b0;
        w0 = wcount;
        repeat (12) @(negedge clk);
        chk("post_rst_no_mclk", {30'd0, bus.state}, 0);
        chk("post_rst_no_wr", 32'(wcount - w0), 0);
        // 2: full 16-bit record with alternating mic pattern
        w0 = wcount;
        d0 = done_cnt;
        issue(1, 0, 0);
        for (int i = 0; i < 400 && bus.state != 2'b00; i++) @(negedge clk);
        chk("rec16_idle", 32'(bus.state), 0);
        chk("rec16_done_high", 32'(bus.done), 1);
        @(negedge clk);
        chk("rec16_done_low", 32'(bus.done), 0);
        chk("rec16_done_count", 32'(done_cnt - d0), 1);
        chk("rec16_writes", 32'(wcount - w0), 16);
        for (int i = 0; i < 16; i++) chk("rec16_din", 32'(wr_bit[(w0 + i) % 64]), 32'(((w0 + i) % 2) == 0));
        for (int i = 1; i < 16; i++) chk("rec16_gap", 32'(wr_t[(w0 + i) % 64] - wr_t[(w0 + i - 1) % 64]), 8);
        chk("rec16_overrun", 32'(bus.overrun), 0);
        // 3: FIFO fills after 5 writes
        w0 = wcount;
        issue(1, 0, 0);
        for (int i = 0; i < 200 && wcount - w0 < 5; i++) @(negedge clk);
        full_force = 1'b1;
        for (int i = 0; i < 200 && bus.state != 2'b00; i++) @(negedge clk);
        chk("ovr_idle", 32'(bus.state), 0);
        chk("ovr_writes", 32'(wcount - w0), 5);
        chk("ovr_flag", 32'(bus.overrun), 1);
        full_force = 1'b0;
        repeat (3) @(negedge clk);
        chk("ovr_sticky", 32'(bus.overrun), 1);
        issue(1, 0, 0);
        chk("ovr_cleared", 32'(bus.overrun), 0);
        issue(0, 0, 1);
        chk("rec_stop_idle", 32'(bus.state), 0);
        // 4: playback of 0110
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        pat = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            pre_bit = pat[i];
            pre_wr = 1'b1;
            @(negedge clk);
        end
        pre_wr = 1'b0;
        chk("preload_not_empty", 32'(bus.fifo_empty), 0);
        r0 = rcount;
        last = rcount;
        cd = 0;
        n = 0;
        sd_bad = 0;
        issue(0, 1, 0);
        chk("play_entry", 32'(bus.state), 2);
        chk("play_sd", 32'(bus.amp_sd), 1);
        for (int i = 0; i < 200 && bus.state == 2'b10; i++) begin
            if (bus.amp_sd !== 1'b1) sd_bad++;
            if (rcount != last) begin
                last = rcount;
                cd = 4;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    pwm_seen[n % 4] = bus.amp_pwm;
                    n++;
                end
            end
            @(negedge clk);
        end
        chk("play_idle", 32'(bus.state), 0);
        chk("play_exit_done", 32'(bus.done), 1);
        chk("play_exit_amp", {bus.amp_sd, bus.amp_pwm}, 0);
        chk("play_sd_held", 32'(sd_bad), 0);
        chk("play_reads", 32'(rcount - r0), 4);
        chk("play_pwm_samples", 32'(n), 4);
        for (int i = 0; i < 4; i++) chk("play_pwm", 32'(pwm_seen[i]), 32'(pat[i]));
        for (int i = 1; i < 4; i++) chk("play_gap", 32'(rd_t[(r0 + i) % 16] - rd_t[(r0 + i - 1) % 16]), 8);
        // 5: play with empty FIFO
        @(negedge clk);
        r0 = rcount;
        d0 = done_cnt;
        issue(0, 1, 0);
        chk("empty_play_state", 32'(bus.state), 0);
        chk("empty_play_done", 32'(bus.done), 1);
        repeat (10) @(negedge clk);
        chk("empty_play_no_rd", 32'(rcount - r0), 0);
        chk("empty_play_done_count", 32'(done_cnt - d0), 1);
        // 6: stop beats rec in IDLE; stop in PLAY drops the pending read
        w0 = wcount;
        issue(1, 0, 1);
        chk("stop_rec_state", 32'(bus.state), 0);
        chk("stop_rec_done", 32'(bus.done), 0);
        repeat (12) @(negedge clk);
        chk("stop_rec_no_wr", 32'(wcount - w0), 0);
        for (int i = 0; i < 2; i++) begin
            pre_bit = 1'b1;
            pre_wr = 1'b1;
            @(negedge clk);
        end
        pre_wr = 1'b0;
        r0 = rcount;
        issue(0, 1, 0);
        for (int i = 0; i < 50 && rcount == r0; i++) @(negedge clk);
        repeat (6) @(negedge clk);
        issue(0, 0, 1);
        chk("play_stop_state", 32'(bus.state), 0);
        chk("play_stop_done", 32'(bus.done), 1);
        chk("play_stop_amp", {bus.amp_sd, bus.amp_pwm, bus.fifo_rd}, 0);
        repeat (20) @(negedge clk);
        chk("play_stop_reads", 32'(rcount - r0), 1);
        chk("strobe_rules", 32'(bad_strobe), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
